// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Optional build macro: FIFO_ERR_FLAGS_EN (sticky overflow/underflow outputs).
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 16;

    // Pointer width: address bits plus one wrap bit that tells full from empty.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The read register clears on reset; the array itself is never cleared.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: register the addressed word; hold it when no read is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count and threshold flags.
// Optional build macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W_DEF,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      data_out,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                   overflow,
    output logic                   underflow,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = fifo_ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_acc;
    logic             wr_acc;

    // Flags come straight from the registered pointers/count, so they track post-edge state.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign almost_full  = (int'(count) >= AF_LEVEL);
    assign almost_empty = (int'(count) <= AE_LEVEL);

    // A read frees a slot in the same edge, so a write at full is taken alongside it.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc && !rst),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (data_out)
    );

    // Pointer, occupancy and read-strobe state; reset discards everything stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
            overflow  <= 1'b0;
            underflow <= 1'b0;
`endif
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            rd_valid <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
`ifdef FIFO_ERR_FLAGS_EN
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (DEPTH=16, DATA_W=8).
// Build with FIFO_ERR_FLAGS_EN defined to also exercise overflow/underflow.
module tb_fifo_sync_param;

    localparam int DW = 8;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fifo_sync_param #(
        .DATA_W   (DW),
        .DEPTH    (DP),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        int            cnt;
        logic [DW-1:0] dout;
        logic          rv;
    } vec_t;

    vec_t tbl[34];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against an expected count/data/strobe triple.
    task automatic check_state(input string name, input int cnt, input int dout, input int rv);
        check({name, ".count"}, int'(count), cnt);
        check({name, ".data_out"}, int'(data_out), dout);
        check({name, ".rd_valid"}, int'(rd_valid), rv);
        check({name, ".full"}, int'(full), int'(cnt == DP));
        check({name, ".empty"}, int'(empty), int'(cnt == 0));
        check({name, ".almost_full"}, int'(almost_full), int'(cnt >= 14));
        check({name, ".almost_empty"}, int'(almost_empty), int'(cnt <= 2));
    endtask

    // One clock: drive on the falling edge, settle just after the rising edge.
    task automatic cycle(input logic r_st, input logic w, input logic r, input logic [DW-1:0] d);
        @(negedge clk);
        rst     = r_st;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Fill-to-full, one rejected write, drain in order, one read on empty.
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{w: 1'b1, r: 1'b0, d: DW'(i), cnt: i + 1, dout: 8'h00, rv: 1'b0};
        end
        tbl[16] = '{w: 1'b1, r: 1'b0, d: 8'hAA, cnt: 16, dout: 8'h00, rv: 1'b0};
        for (int i = 0; i < 16; i++) begin
            tbl[17 + i] = '{w: 1'b0, r: 1'b1, d: 8'h00, cnt: 15 - i, dout: DW'(i), rv: 1'b1};
        end
        tbl[33] = '{w: 1'b0, r: 1'b1, d: 8'h00, cnt: 0, dout: 8'h0F, rv: 1'b0};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check_state("reset", 0, 0, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("reset.overflow", int'(overflow), 0);
        check("reset.underflow", int'(underflow), 0);
`endif

        for (int i = 0; i < 34; i++) begin
            cycle(1'b0, tbl[i].w, tbl[i].r, tbl[i].d);
            check_state($sformatf("tbl%0d", i), tbl[i].cnt, int'(tbl[i].dout), int'(tbl[i].rv));
        end
`ifdef FIFO_ERR_FLAGS_EN
        check("tbl.overflow", int'(overflow), 1);
        check("tbl.underflow", int'(underflow), 1);
`endif

        // Simultaneous read and write while full.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, DW'(8'h10 + i));
        end
        check_state("full_fill", 16, 8'h0F, 0);
        cycle(1'b0, 1'b1, 1'b1, 8'h55);
        check_state("full_rw", 16, 8'h10, 1);
        for (int i = 1; i < 16; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            check_state($sformatf("full_drain%0d", i), 16 - i, 8'h10 + i, 1);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("full_last55", 0, 8'h55, 1);

        // Simultaneous read and write while empty: only the write goes in.
        cycle(1'b0, 1'b1, 1'b1, 8'h33);
        check_state("empty_rw", 1, 8'h55, 0);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("empty_rd33", 0, 8'h33, 1);

        // Threshold edges on the way up and down.
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b1, 1'b0, DW'(8'h40 + i));
            if (i == 1)  check("ae_at2_up", int'(almost_empty), 1);
            if (i == 2)  check("ae_at3_up", int'(almost_empty), 0);
            if (i == 12) check("af_at13_up", int'(almost_full), 0);
            if (i == 13) check("af_at14_up", int'(almost_full), 1);
        end
        check_state("thr_top", 14, 8'h33, 0);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            check_state($sformatf("thr_rd%0d", i), 13 - i, 8'h40 + i, 1);
            if (i == 0)  check("af_at13_down", int'(almost_full), 0);
            if (i == 10) check("ae_at3_down", int'(almost_empty), 0);
            if (i == 11) check("ae_at2_down", int'(almost_empty), 1);
        end

        // Reset in the middle of a write burst discards the contents.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, DW'(8'hC0 + i));
        end
        check_state("mid_fill", 5, 8'h4D, 0);
        cycle(1'b1, 1'b1, 1'b0, 8'hEE);
        check_state("mid_rst", 0, 0, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("mid_rst.underflow", int'(underflow), 0);
        check("mid_rst.overflow", int'(overflow), 0);
`endif
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("post_rst_rd", 0, 0, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("uf_set", int'(underflow), 1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("uf_sticky", int'(underflow), 1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("uf_cleared", int'(underflow), 0);
`endif
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check_state("final_idle", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
